system_irq_ctrl: RTL and testbench
==================================

# system_irq_ctrl

Memory-mapped interrupt controller sitting directly downstream of the system interval timer and other peripheral IRQ lines, between those sources and the CPU's single interrupt input. It synchronizes up to 16 raw IRQ lines, latches them as level- or edge-triggered pending bits, applies a per-source mask, and presents a prioritized vector plus one registered IRQ. A programmable holdoff counter suppresses the CPU IRQ for a set number of cycles after software clears pending bits (interrupt coalescing for periodic timer ticks).

## Interface
- N_SRC, 8, number of IRQ sources (1..16); source 0 is the timer irq
- HOLDOFF_RST, 0, reset value of HOLDOFF register (16-bit)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  16  write data
- irq_in  in  N_SRC  raw peripheral IRQ lines, asynchronous to clk allowed
- readdata  out  16  registered read data
- irq  out  1  registered interrupt request to CPU

## Operation
- Write strobe = chipselect && ~write_n; writes take effect on the clock edge where strobe is high. No wait states.
- Register map (bits >= N_SRC read 0, writes ignored):
  - 0 RAW (RO): synchronized irq_in levels.
  - 1 PENDING (R/W1C): writing 1 clears bit; 0 no effect.
  - 2 MASK (RW, reset 0): 1 = source enabled.
  - 3 EDGE (RW, reset 0): 1 = rising-edge mode, 0 = level mode.
  - 4 VECTOR (RO): bit15 = valid (any pending&mask), bits[3:0] = lowest index i with pending[i]&mask[i]; 0x0000 when none.
  - 5 HOLDOFF (RW, reset HOLDOFF_RST): suppression length in cycles.
  - 6,7: read 0x0000, writes ignored.
- Synchronizer: two flops per source (sync1, sync2), plus prev flop of sync2 for edge detect; all reset 0.
- Pending set condition: level mode: sync2[i]==1; edge mode: sync2[i]&~prev[i].
- Set and W1C in same cycle: set wins (bit stays 1). Level-mode source still high re-sets after clear.
- Pending latches regardless of mask; unmasking a pending source raises irq.
- Changing EDGE bit does not alter existing pending bits.
- Holdoff counter (16-bit): loaded with HOLDOFF register on any PENDING write with writedata[N_SRC-1:0] != 0; otherwise decrements by 1 when nonzero, saturates at 0. HOLDOFF=0 means no suppression.
- irq <= (|(pending & mask)) && (holdoff_cnt == 0), registered.

## Timing
- Reset values: readdata 0, irq 0, pending 0, mask 0, edge 0, holdoff_cnt 0, sync/prev flops 0.
- irq_in rising before edge E0: sync1 at E0, sync2 at E1, pending at E2, irq at E3 (enabled source, no holdoff).
- Read latency 1: readdata <= mux(address) on every clock edge regardless of chipselect; value reflects register state before that edge.
- W1C at edge Ew (no re-set): pending clears at Ew; irq deasserts at Ew+1.
- Holdoff: PENDING write at Ew with HOLDOFF=H>0 loads counter H at Ew; irq held 0 through edge Ew+H; earliest irq assertion at edge Ew+H+1 if pending&mask.
- Reset assertion mid-operation clears everything asynchronously; pulse on irq_in during reset is lost.
- Edge pulses shorter than one clk period may be missed; lines must be held ≥2 clk cycles.

## Test plan
- Reset, read all addresses 0..7 -> readdata 0x0000 except HOLDOFF = HOLDOFF_RST; irq 0.
- MASK=0x0001, EDGE=0, irq_in[0] high at cycle 0 -> irq 1 at third edge; VECTOR=0x8000; W1C 0x0001 while high -> pending re-set next cycle, irq stays/returns 1.
- EDGE=0x0004, MASK=0x0004, 3-cycle pulse on irq_in[2] -> PENDING=0x0004 latched after pulse ends; VECTOR=0x8002; W1C 0x0004 -> PENDING 0, irq 0 next cycle.
- Sources 3 and 5 pending, MASK=0x0028 -> VECTOR=0x8003; MASK=0x0020 -> VECTOR=0x8005; MASK=0 -> VECTOR=0x0000, irq 0, PENDING still 0x0028.
- HOLDOFF=10, periodic edge on source 0 every 4 cycles, W1C at Ew -> irq 0 through Ew+10, 1 at Ew+11.
- Rising edge coincident with W1C of same bit -> PENDING bit remains 1; reset_n pulsed mid-holdoff -> counter 0, all registers at reset values.

Source files
------------

// File: rtl/system_irq_ctrl.sv
// Memory-mapped interrupt controller: synchronizes raw IRQ lines, latches level/edge
// pending bits, masks and prioritizes them, and drives one registered CPU irq with holdoff.
module system_irq_ctrl #(
  parameter int          N_SRC       = 8,
  parameter logic [15:0] HOLDOFF_RST = 16'h0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  input  logic [N_SRC-1:0] irq_in,
  output logic [15:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] A_RAW     = 3'd0;
  localparam logic [2:0] A_PENDING = 3'd1;
  localparam logic [2:0] A_MASK    = 3'd2;
  localparam logic [2:0] A_EDGE    = 3'd3;
  localparam logic [2:0] A_VECTOR  = 3'd4;
  localparam logic [2:0] A_HOLDOFF = 3'd5;

  logic [N_SRC-1:0] r_sync1;
  logic [N_SRC-1:0] r_sync2;
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_edge;
  logic [15:0]      r_holdoff;
  logic [15:0]      r_hold_cnt;
  logic [15:0]      r_readdata;
  logic             r_irq;

  logic             w_wr;
  logic             w_wr_pend;
  logic             w_hold_load;
  logic [N_SRC-1:0] w_wdat;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_active;
  logic [15:0]      w_vector;
  logic [15:0]      w_rdmux;

  function automatic logic [3:0] lowest_idx(input logic [N_SRC-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [15:0] zext(input logic [N_SRC-1:0] v);
    logic [15:0] r;
    r = '0;
    r[N_SRC-1:0] = v;
    return r;
  endfunction

  assign w_wr        = chipselect & ~write_n;
  assign w_wdat      = writedata[N_SRC-1:0];
  assign w_wr_pend   = w_wr && (address == A_PENDING);
  assign w_hold_load = w_wr_pend && (w_wdat != '0);
  assign w_clr       = w_wr_pend ? w_wdat : '0;
  // Set is applied after the clear so a coincident event keeps the bit.
  assign w_set       = (r_sync2 & ~r_edge) | (r_sync2 & ~r_prev & r_edge);
  assign w_active    = r_pending & r_mask;
  assign w_vector    = (|w_active) ? {1'b1, 11'b0, lowest_idx(w_active)} : 16'h0000;

  always_comb begin
    w_rdmux = 16'h0000;
    case (address)
      A_RAW:     w_rdmux = zext(r_sync2);
      A_PENDING: w_rdmux = zext(r_pending);
      A_MASK:    w_rdmux = zext(r_mask);
      A_EDGE:    w_rdmux = zext(r_edge);
      A_VECTOR:  w_rdmux = w_vector;
      A_HOLDOFF: w_rdmux = r_holdoff;
      default:   w_rdmux = 16'h0000;
    endcase
  end

  // Synchronizer and edge-detect stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Register file, pending latch and holdoff counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending  <= '0;
      r_mask     <= '0;
      r_edge     <= '0;
      r_holdoff  <= HOLDOFF_RST;
      r_hold_cnt <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_wr && (address == A_MASK))    r_mask    <= w_wdat;
      if (w_wr && (address == A_EDGE))    r_edge    <= w_wdat;
      if (w_wr && (address == A_HOLDOFF)) r_holdoff <= writedata;
      if (w_hold_load)                    r_hold_cnt <= r_holdoff;
      else if (r_hold_cnt != '0)          r_hold_cnt <= r_hold_cnt - 16'd1;
    end
  end

  // Output stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_readdata <= w_rdmux;
      r_irq      <= (|w_active) && (r_hold_cnt == '0);
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_system_irq_ctrl.sv
// Bench for system_irq_ctrl: per-cycle comparison against a cycle-indexed model of the
// register rules, plus directed vectors with literal expectations.
module tb_system_irq_ctrl;
  localparam int N = 8;
  localparam logic [15:0] HRST = 16'h0007;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [15:0]   writedata = '0;
  logic [N-1:0]  irq_in = '0;
  logic [15:0]   readdata;
  logic          irq;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  system_irq_ctrl #(.N_SRC(N), .HOLDOFF_RST(HRST)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .irq_in(irq_in),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: s_hist[k] is irq_in as sampled at edge k since reset; the value a source
  // presents to the pending logic at edge k is s_hist[k-2], its predecessor s_hist[k-3].
  logic [N-1:0] s_hist [0:1023];
  int           k = 0;
  int           hold_until = -1;
  logic [N-1:0] m_pend = '0, m_mask = '0, m_edge = '0;
  logic [N-1:0] m_lv, m_pv, m_set, m_clr;
  logic [15:0]  m_hold = HRST;
  logic [15:0]  m_rd = '0;
  logic         m_irq = 1'b0;

  function automatic logic [N-1:0] samp(input int j);
    if (j < 0) return '0;
    return s_hist[j % 1024];
  endfunction

  function automatic logic [15:0] vec(input logic [N-1:0] act);
    for (int i = 0; i < N; i++) begin
      if (act[i]) return {1'b1, 11'b0, i[3:0]};
    end
    return 16'h0000;
  endfunction

  function automatic logic [15:0] ext(input logic [N-1:0] v);
    return {{(16-N){1'b0}}, v};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k = 0; hold_until = -1;
      m_pend = '0; m_mask = '0; m_edge = '0; m_hold = HRST;
      m_rd = '0; m_irq = 1'b0;
    end else begin
      s_hist[k % 1024] = irq_in;
      m_lv = samp(k - 2);
      m_pv = samp(k - 3);
      case (address)
        3'd0: m_rd = ext(m_lv);
        3'd1: m_rd = ext(m_pend);
        3'd2: m_rd = ext(m_mask);
        3'd3: m_rd = ext(m_edge);
        3'd4: m_rd = vec(m_pend & m_mask);
        3'd5: m_rd = m_hold;
        default: m_rd = 16'h0000;
      endcase
      m_irq = (|(m_pend & m_mask)) && (k > hold_until);
      m_set = 0;
      for (int i = 0; i < N; i++)
        m_set[i] = m_edge[i] ? (m_lv[i] && !m_pv[i]) : m_lv[i];
      m_clr = '0;
      if (chipselect && !write_n) begin
        case (address)
          3'd1: begin
            m_clr = writedata[N-1:0];
            if (writedata[N-1:0] != 0) hold_until = k + int'(m_hold);
          end
          3'd2: m_mask = writedata[N-1:0];
          3'd3: m_edge = writedata[N-1:0];
          3'd5: m_hold = writedata;
          default: ;
        endcase
      end
      m_pend = (m_pend & ~m_clr) | m_set;
      k = k + 1;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("irq_cycle", {15'b0, irq}, {15'b0, m_irq});
      chk("readdata_cycle", readdata, m_rd);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string nm);
    address = a;
    cyc(1);
    chk(nm, readdata, exp);
  endtask

  task automatic irq_is(input logic exp, input string nm);
    chk(nm, {15'b0, irq}, {15'b0, exp});
  endtask

  initial begin
    // Reset and register read-back
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    chk_en = 1'b1;
    cyc(1);
    irq_is(1'b0, "reset_irq");
    for (int a = 0; a < 8; a++) rd(3'(a), (a == 5) ? HRST : 16'h0000, "reset_read");
    wr(3'd5, 16'h0000);

    // Level mode on source 0
    wr(3'd2, 16'h0001);
    irq_in[0] = 1'b1;
    cyc(3);
    irq_is(1'b0, "level_irq_e2");
    cyc(1);
    irq_is(1'b1, "level_irq_e3");
    rd(3'd4, 16'h8000, "level_vector");
    wr(3'd1, 16'h0001);
    rd(3'd1, 16'h0001, "level_reset_after_w1c");
    irq_is(1'b1, "level_irq_stays");
    irq_in[0] = 1'b0;
    cyc(4);
    wr(3'd1, 16'h0001);
    cyc(1);
    irq_is(1'b0, "level_irq_cleared");

    // Edge mode on source 2
    wr(3'd3, 16'h0004);
    wr(3'd2, 16'h0004);
    irq_in[2] = 1'b1;
    cyc(3);
    irq_in[2] = 1'b0;
    cyc(4);
    rd(3'd1, 16'h0004, "edge_pending");
    rd(3'd4, 16'h8002, "edge_vector");
    irq_is(1'b1, "edge_irq");
    wr(3'd1, 16'h0004);
    cyc(1);
    irq_is(1'b0, "edge_irq_cleared");
    rd(3'd1, 16'h0000, "edge_pending_cleared");

    // Priority and masking with sources 3 and 5
    wr(3'd2, 16'h0028);
    irq_in[3] = 1'b1; irq_in[5] = 1'b1;
    cyc(4);
    rd(3'd4, 16'h8003, "prio_vec_35");
    wr(3'd2, 16'h0020);
    rd(3'd4, 16'h8005, "prio_vec_5");
    wr(3'd2, 16'h0000);
    rd(3'd4, 16'h0000, "prio_vec_none");
    irq_is(1'b0, "prio_irq_masked");
    rd(3'd1, 16'h0028, "prio_pending_kept");
    irq_in = '0;
    cyc(3);
    wr(3'd1, 16'h0028);
    rd(3'd1, 16'h0000, "prio_pending_cleared");

    // Holdoff of 10 cycles with periodic edges on source 0
    wr(3'd5, 16'd10);
    rd(3'd5, 16'd10, "holdoff_read");
    wr(3'd3, 16'h0001);
    wr(3'd2, 16'h0001);
    for (int c = 0; c < 36; c++) begin
      irq_in[0] = (c % 4) < 2;
      if (c == 12) begin
        address = 3'd1; writedata = 16'h0001; chipselect = 1'b1; write_n = 1'b0;
      end else begin
        chipselect = 1'b0; write_n = 1'b1;
      end
      cyc(1);
      if (c >= 13 && c <= 22) irq_is(1'b0, "holdoff_suppressed");
      if (c == 23) irq_is(1'b1, "holdoff_release");
    end
    chipselect = 1'b0; write_n = 1'b1;
    irq_in[0] = 1'b0;

    // Rising edge coincident with W1C of the same bit
    wr(3'd5, 16'h0000);
    cyc(4);
    wr(3'd1, 16'h0001);
    rd(3'd1, 16'h0000, "coinc_pre_clear");
    irq_in[0] = 1'b1;
    cyc(2);
    wr(3'd1, 16'h0001);
    rd(3'd1, 16'h0001, "coinc_set_wins");

    // Reset in the middle of a holdoff window; pulse during reset is lost
    wr(3'd5, 16'd20);
    wr(3'd1, 16'h0001);
    cyc(3);
    reset_n = 1'b0;
    irq_in = '0;
    irq_in[1] = 1'b1;
    cyc(2);
    irq_in[1] = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    irq_is(1'b0, "reset2_irq");
    for (int a = 0; a < 8; a++) rd(3'(a), (a == 5) ? HRST : 16'h0000, "reset2_read");
    wr(3'd2, 16'h0002);
    irq_in[1] = 1'b1;
    cyc(3);
    irq_is(1'b0, "reset2_irq_e2");
    cyc(1);
    irq_is(1'b1, "reset2_irq_e3");
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
